// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and default timing constants for the timer
//                input blocks (repeat-FSM state encoding, debounce/repeat/
//                tick defaults for a 100 MHz system clock).
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Auto-repeat state machine states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Default timing at 100 MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;  // 0.1 s
  localparam int unsigned DEF_TICK_DIV        = 100_000_000; // 1 s

  // Width of a counter that runs 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchroniser followed by a consecutive-cycle
//                debounce counter. Provides the registered stable level and
//                a one-cycle pulse in the cycle the level rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  // Synchroniser shift and debounce decision: the level only follows the
  // synchronised input once it has differed for DEBOUNCE_CYCLES cycles in a
  // row; any cycle agreeing with the stable level restarts the count.
  always_comb begin
    sync_d  = {sync_q[0], i_raw};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule
`default_nettype wire

// File: rtl/timer_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : timer_input_conditioner
//  Description : Turns raw buttons and the run switch into clean single-cycle
//                control strobes for the countdown timer: debounced sec/min
//                increments with auto-repeat, a clear strobe, the debounced
//                run level and a 1 Hz tick enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_input_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned TICK_DIV        = DEF_TICK_DIV
) (
  input  logic clk_100MHz,
  input  logic reset_st_n,
  input  logic btn_secplus,
  input  logic btn_minplus,
  input  logic btn_reset,
  input  logic sw_timeset,
  output logic sec_inc,
  output logic min_inc,
  output logic clr,
  output logic run,
  output logic tick_1hz
);

  localparam int unsigned   RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                          REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned   RW          = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  localparam int unsigned   TW          = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

  // Index 0 is the seconds button, index 1 the minutes button.
  logic [1:0] btn_level;
  logic [1:0] btn_rise;
  logic [1:0] rpt_fire;
  logic       clr_level, clr_rise;
  logic       run_level, run_rise;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sec (
    .clk(clk_100MHz), .rst_n(reset_st_n), .i_raw(btn_secplus),
    .o_level(btn_level[0]), .o_rise(btn_rise[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
    .clk(clk_100MHz), .rst_n(reset_st_n), .i_raw(btn_minplus),
    .o_level(btn_level[1]), .o_rise(btn_rise[1])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk_100MHz), .rst_n(reset_st_n), .i_raw(btn_reset),
    .o_level(clr_level), .o_rise(clr_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk_100MHz), .rst_n(reset_st_n), .i_raw(sw_timeset),
    .o_level(run_level), .o_rise(run_rise)
  );

  // One auto-repeat FSM per increment button.
  for (genvar i = 0; i < 2; i++) begin : g_rpt
    rpt_state_e    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          fire;

    // Next state: first strobe on press, one after the hold delay, then one
    // per repeat period. A release wins over a strobe due in the same cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_rise[i]) begin
            fire    = 1'b1;
            state_d = DELAY;
            cnt_d   = '0;
          end
        end
        DELAY: begin
          if (!btn_level[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            fire    = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        REPEAT: begin
          if (!btn_level[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            fire  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + RW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // FSM state register.
    always_ff @(posedge clk_100MHz or negedge reset_st_n) begin
      if (!reset_st_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign rpt_fire[i] = fire;
  end

  logic          sec_inc_q, sec_inc_d;
  logic          min_inc_q, min_inc_d;
  logic          clr_q, clr_d;
  logic          run_q, run_d;
  logic          tick_q, tick_d;
  logic [TW-1:0] div_q, div_d;
  logic          blocked;
  logic          restart;

  // Output strobes with interlocks, plus the tick divider. Increments are
  // held off while running or while clear is held; minutes beat seconds.
  // The divider restarts on clear and on run start, and a restart in the
  // wrap cycle swallows that tick so the next one is a full period away.
  always_comb begin
    blocked   = run_level | clr_level;
    min_inc_d = rpt_fire[1] & ~blocked;
    sec_inc_d = rpt_fire[0] & ~rpt_fire[1] & ~blocked;
    clr_d     = clr_rise;
    run_d     = run_level;
    restart   = clr_rise | run_rise;
    tick_d    = 1'b0;
    div_d     = div_q + TW'(1);
    if (restart) begin
      div_d = '0;
    end else if (div_q == TICK_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Output and divider registers.
  always_ff @(posedge clk_100MHz or negedge reset_st_n) begin
    if (!reset_st_n) begin
      sec_inc_q <= 1'b0;
      min_inc_q <= 1'b0;
      clr_q     <= 1'b0;
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
      div_q     <= '0;
    end else begin
      sec_inc_q <= sec_inc_d;
      min_inc_q <= min_inc_d;
      clr_q     <= clr_d;
      run_q     <= run_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
    end
  end

  assign sec_inc  = sec_inc_q;
  assign min_inc  = min_inc_q;
  assign clr      = clr_q;
  assign run      = run_q;
  assign tick_1hz = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_input_conditioner
//  Description : Directed scoreboard bench for timer_input_conditioner.
//                Stimulus pushes the cycle at which each strobe is due; a
//                negedge monitor pops and compares whenever a strobe shows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_input_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam int TDIV = 10;
  // Raw edge to visible strobe: 2 sync + DEB debounce + 1 output register.
  localparam int LAT  = 2 + DEB + 1;

  logic clk = 1'b0;
  logic reset_st_n = 1'b0;
  logic btn_secplus = 1'b0;
  logic btn_minplus = 1'b0;
  logic btn_reset = 1'b0;
  logic sw_timeset = 1'b0;
  logic sec_inc, min_inc, clr, run, tick_1hz;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int q_sec[$];
  int q_min[$];
  int q_clr[$];
  int q_tick[$];
  bit tick_chk = 1'b0;

  timer_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RDLY),
    .REPEAT_PERIOD(RPER),
    .TICK_DIV(TDIV)
  ) dut (
    .clk_100MHz (clk),
    .reset_st_n (reset_st_n),
    .btn_secplus(btn_secplus),
    .btn_minplus(btn_minplus),
    .btn_reset  (btn_reset),
    .sw_timeset (sw_timeset),
    .sec_inc    (sec_inc),
    .min_inc    (min_inc),
    .clr        (clr),
    .run        (run),
    .tick_1hz   (tick_1hz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Monitor: every visible strobe must match the oldest expected cycle.
  always @(negedge clk) begin
    if (sec_inc) begin
      if (q_sec.size() == 0) chk("sec_inc unexpected (cycle)", cyc, -1);
      else chk("sec_inc cycle", cyc, q_sec.pop_front());
    end
    if (min_inc) begin
      if (q_min.size() == 0) chk("min_inc unexpected (cycle)", cyc, -1);
      else chk("min_inc cycle", cyc, q_min.pop_front());
    end
    if (clr) begin
      if (q_clr.size() == 0) chk("clr unexpected (cycle)", cyc, -1);
      else chk("clr cycle", cyc, q_clr.pop_front());
    end
    if (tick_chk && tick_1hz) begin
      if (q_tick.size() == 0) chk("tick_1hz unexpected (cycle)", cyc, -1);
      else chk("tick_1hz cycle", cyc, q_tick.pop_front());
    end
  end

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    chk({nm, " sec_inc missing"}, q_sec.size(), 0);
    chk({nm, " min_inc missing"}, q_min.size(), 0);
    chk({nm, " clr missing"}, q_clr.size(), 0);
    chk({nm, " tick missing"}, q_tick.size(), 0);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset sec_inc", sec_inc, 0);
    chk("reset min_inc", min_inc, 0);
    chk("reset clr", clr, 0);
    chk("reset run", run, 0);
    chk("reset tick_1hz", tick_1hz, 0);

    // Divider starts from 0 at reset release.
    reset_st_n = 1'b1;
    c = cyc;
    q_tick.push_back(c + TDIV);
    tick_chk = 1'b1;
    go(c + TDIV + 2);
    tick_chk = 1'b0;
    drain("post-reset");

    // Bounce: six 2-cycle toggles, then hold high.
    c = cyc;
    for (int k = 0; k < 6; k++) begin
      btn_secplus = (k % 2 == 0);
      go(c + 2 * (k + 1));
    end
    btn_secplus = 1'b1;
    c = cyc;
    q_sec.push_back(c + LAT);
    go(c + 10);
    btn_secplus = 1'b0;
    go(c + 40);
    drain("bounce");

    // Auto-repeat on minutes; release lands exactly on the 40th cycle.
    c = cyc;
    btn_minplus = 1'b1;
    q_min.push_back(c + LAT);
    q_min.push_back(c + LAT + 20);
    q_min.push_back(c + LAT + 25);
    q_min.push_back(c + LAT + 30);
    q_min.push_back(c + LAT + 35);
    go(c + 40);
    btn_minplus = 1'b0;
    go(c + 80);
    drain("auto-repeat");

    // Run: ticks restart from run rise; sec suppressed until run drops.
    c = cyc;
    sw_timeset = 1'b1;
    go(c + 8);
    chk("run high", run, 1);
    tick_chk = 1'b1;
    q_tick.push_back(c + 17);
    q_tick.push_back(c + 27);
    q_tick.push_back(c + 37);
    q_tick.push_back(c + 47);
    go(c + 10);
    btn_secplus = 1'b1;
    q_sec.push_back(c + 37);
    q_sec.push_back(c + 42);
    q_sec.push_back(c + 47);
    go(c + 30);
    sw_timeset = 1'b0;
    go(c + 43);
    btn_secplus = 1'b0;
    go(c + 50);
    tick_chk = 1'b0;
    chk("run low", run, 0);
    go(c + 75);
    drain("run");

    // Simultaneous sec+min: only min_inc, both on press and after delay.
    c = cyc;
    btn_secplus = 1'b1;
    btn_minplus = 1'b1;
    q_min.push_back(c + LAT);
    q_min.push_back(c + LAT + 20);
    go(c + 25);
    btn_secplus = 1'b0;
    btn_minplus = 1'b0;
    go(c + 60);
    drain("simultaneous");

    // Clear during sec REPEAT; second clear lands on a divider wrap.
    c = cyc;
    btn_secplus = 1'b1;
    q_sec.push_back(c + 7);
    q_sec.push_back(c + 27);
    q_sec.push_back(c + 32);
    go(c + 30);
    btn_reset = 1'b1;
    q_clr.push_back(c + 37);
    q_sec.push_back(c + 57);
    q_sec.push_back(c + 62);
    go(c + 38);
    tick_chk = 1'b1;
    q_tick.push_back(c + 47);
    q_tick.push_back(c + 57);
    q_tick.push_back(c + 77);
    go(c + 50);
    btn_reset = 1'b0;
    go(c + 58);
    btn_secplus = 1'b0;
    go(c + 60);
    btn_reset = 1'b1;
    q_clr.push_back(c + 67);
    go(c + 70);
    btn_reset = 1'b0;
    go(c + 80);
    tick_chk = 1'b0;
    go(c + 100);
    drain("clear");

    // Asynchronous reset while min_inc is high and the FSM is in DELAY.
    c = cyc;
    btn_minplus = 1'b1;
    q_min.push_back(c + LAT);
    go(c + LAT);
    #2 reset_st_n = 1'b0;
    #1;
    chk("async reset min_inc", min_inc, 0);
    chk("async reset sec_inc", sec_inc, 0);
    chk("async reset clr", clr, 0);
    chk("async reset run", run, 0);
    chk("async reset tick_1hz", tick_1hz, 0);
    go(c + 10);
    reset_st_n = 1'b1;
    q_min.push_back(c + 10 + LAT);
    go(c + 25);
    btn_minplus = 1'b0;
    go(c + 60);
    drain("mid-reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
